// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle sequencing controller for the lab CPU datapath (Moore outputs only).
// Optional CTRL_INSTR_CNT_EN adds a 16-bit retired-instruction counter output.
module cpu_ctrl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       err
`ifdef CTRL_INSTR_CNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  localparam logic [4:0] InstrMovImm = 5'b110_10;
  localparam logic [4:0] InstrMovReg = 5'b110_00;
  localparam logic [4:0] InstrAdd    = 5'b101_00;
  localparam logic [4:0] InstrCmp    = 5'b101_01;
  localparam logic [4:0] InstrAnd    = 5'b101_10;
  localparam logic [4:0] InstrMvn    = 5'b101_11;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StAlu,
    StStatus,
    StWriteReg,
    StWriteImm
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] instr_q, instr_d;
  logic       accept;

  assign accept = (state_q == StWait) && s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWait;
      instr_q <= 5'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = accept ? {opcode, op} : instr_q;
    unique case (state_q)
      StWait:   if (s) state_d = StDecode;
      StDecode: begin
        case (instr_q)
          InstrMovImm:                    state_d = StWriteImm;
          InstrMovReg, InstrMvn:          state_d = StGetB;
          InstrAdd, InstrAnd, InstrCmp:   state_d = StGetA;
          default:                        state_d = StWait;
        endcase
      end
      StGetA:   state_d = StGetB;
      StGetB:   state_d = (instr_q == InstrCmp) ? StStatus : StAlu;
      StAlu:    state_d = StWriteReg;
      StStatus, StWriteReg, StWriteImm: state_d = StWait;
      default:  state_d = StWait;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    vsel  = 2'b00;
    write = 1'b0;
    err   = 1'b0;
    unique case (state_q)
      StWait:   w = 1'b1;
      StDecode: begin
        case (instr_q)
          InstrMovImm, InstrMovReg, InstrAdd, InstrCmp, InstrAnd, InstrMvn: err = 1'b0;
          default: err = 1'b1;
        endcase
      end
      StGetA: begin
        nsel  = 3'b100;
        loada = 1'b1;
      end
      StGetB: begin
        nsel  = 3'b001;
        loadb = 1'b1;
      end
      StAlu: begin
        loadc = 1'b1;
        asel  = (instr_q == InstrMovReg);
      end
      StStatus: loads = 1'b1;
      StWriteReg: begin
        nsel  = 3'b010;
        vsel  = 2'b00;
        write = 1'b1;
      end
      StWriteImm: begin
        nsel  = 3'b100;
        vsel  = 2'b10;
        write = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CTRL_INSTR_CNT_EN
  logic [15:0] instr_cnt_q, instr_cnt_d;
  logic        retire;

  // Only completing states count; the illegal path goes DECODE -> WAIT and is excluded.
  assign retire = (state_q == StStatus) || (state_q == StWriteReg) || (state_q == StWriteImm);

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (retire) instr_cnt_d = instr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) instr_cnt_q <= 16'd0;
    else       instr_cnt_q <= instr_cnt_d;
  end

  assign instr_count = instr_cnt_q;
`endif

endmodule
